// File: rtl/dmem_cache_if.sv
// Core data-memory port and block-wide main-memory bus of the data cache.
// The cache takes the slave view; the core and main memory take the master view.
interface dmem_cache_if #(
    parameter int ADDR_W = 7,
    parameter int BLK_W  = 5,
    parameter int LINE_W = 128
);
    logic              p_cen;
    logic              p_wen;
    logic [ADDR_W-1:0] p_a;
    logic [31:0]       p_wdata;
    logic [31:0]       p_rdata;
    logic              p_stall;
    logic              mem_read;
    logic              mem_write;
    logic [BLK_W-1:0]  mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  p_cen, p_wen, p_a, p_wdata, mem_rdata, mem_ready,
        output p_rdata, p_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output p_cen, p_wen, p_a, p_wdata, mem_rdata, mem_ready,
        input  p_rdata, p_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the single-cycle core.
// Hits answer combinationally; misses stall the core while the line is written
// back (if dirty) and refilled over the ready-handshaked block bus.
module dmem_cache #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input logic         clk,
    input logic         rst,
    dmem_cache_if.slave bus
);
    localparam int ADDR_W = 7;
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 32 * WORDS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WB     = 2'd1;
    localparam logic [1:0] ALLOC  = 2'd2;
    localparam logic [1:0] FILLED = 2'd3;

    logic [1:0]        state;
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [TAG_W-1:0]  ptag;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] merged;
    logic              hit;

    assign idx  = bus.p_a[OFF_W +: IDX_W];
    assign off  = bus.p_a[OFF_W-1:0];
    assign ptag = bus.p_a[ADDR_W-1 -: TAG_W];
    assign line = data_mem[idx];
    assign hit  = !bus.p_cen && valid[idx] && (tag_mem[idx] == ptag);

    // Addressed line with the store word substituted at the current offset.
    always_comb begin
        merged = line;
        merged[32*off +: 32] = bus.p_wdata;
    end

    // Core and memory-bus outputs decoded from state and the indexed line; all forced low in reset.
    always_comb begin
        bus.p_rdata   = '0;
        bus.p_stall   = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (!bus.p_cen) begin
                        if (hit) begin
                            bus.p_rdata = line[32*off +: 32];
                        end else begin
                            bus.p_stall = 1'b1;
                        end
                    end
                end
                WB: begin
                    bus.p_stall   = 1'b1;
                    bus.mem_write = 1'b1;
                    bus.mem_addr  = {tag_mem[idx], idx};
                    bus.mem_wdata = line;
                end
                ALLOC: begin
                    bus.p_stall  = 1'b1;
                    bus.mem_read = 1'b1;
                    bus.mem_addr = {ptag, idx};
                end
                default: begin
                    bus.p_stall = 1'b1;
                end
            endcase
        end
    end

    // Miss FSM plus valid/dirty bookkeeping; reset drops every line and any bus request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.p_cen) begin
                        if (hit) begin
                            if (!bus.p_wen) begin
                                dirty[idx] <= 1'b1;
                            end
                        end else begin
                            state <= (valid[idx] && dirty[idx]) ? WB : ALLOC;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ready) begin
                        state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (bus.mem_ready) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state      <= FILLED;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays: store hits merge one word, accepted refills replace the whole line.
    always_ff @(posedge clk) begin
        if (state == IDLE && hit && !bus.p_wen) begin
            data_mem[idx] <= merged;
        end else if (state == ALLOC && bus.mem_ready) begin
            data_mem[idx] <= bus.mem_rdata;
            tag_mem[idx]  <= ptag;
        end
    end
endmodule
